// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive stages.
// Bit timing defaults to 10 MHz / 115200 baud.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int CLKS_PER_BIT_DEF = 87;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      CLEANUP,
      BREAK_WAIT
   } rx_state_t;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Serial line in, recovered byte stream out.
// The master drives the line and consumes bytes; the slave is the deframer.
interface uart_rx_deframer_if;
   import uart_pkg::*;

   logic                 i_Rx_Serial;
   logic                 o_Rx_DV;
   logic [DATA_BITS-1:0] o_Rx_Byte;
   logic                 o_Frame_Err;
   logic                 o_Rx_Busy;

   modport master (
      output i_Rx_Serial,
      input  o_Rx_DV,
      input  o_Rx_Byte,
      input  o_Frame_Err,
      input  o_Rx_Busy
   );

   modport slave (
      input  i_Rx_Serial,
      output o_Rx_DV,
      output o_Rx_Byte,
      output o_Frame_Err,
      output o_Rx_Busy
   );

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line stays idle-high.
module uart_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 receiver, mid-bit sampling. Line fall to o_Rx_DV rise takes
// 4 + (CPB-1)/2 + 9*CPB rising edges, first edge to see the low line = 1.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_rx_deframer_if.slave   rx
);

   if (CLKS_PER_BIT < 4) begin : g_cpb_chk
      $error("uart_rx_deframer: CLKS_PER_BIT must be >= 4");
   end

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

   rx_state_t            state;
   rx_state_t            state_n;
   logic [CNT_W-1:0]     clk_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] byte_q;
   logic                 dv_q;
   logic                 fe_q;
   logic                 busy;
   logic                 rx_s;
   logic                 bit_end;
   logic                 mid_start;

   uart_sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx.i_Rx_Serial),
      .q     (rx_s)
   );

   assign bit_end   = (clk_cnt == CNT_MAX);
   assign mid_start = (clk_cnt == CNT_MID);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:       if (!rx_s) state_n = START;
         START:      if (mid_start) state_n = rx_s ? IDLE : DATA;
         DATA:       if (bit_end && bit_idx == IDX_MAX) state_n = STOP;
         STOP:       if (bit_end) state_n = rx_s ? CLEANUP : BREAK_WAIT;
         CLEANUP:    state_n = IDLE;
         BREAK_WAIT: if (rx_s) state_n = IDLE;
         default:    state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         byte_q    <= '0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         dv_q <= 1'b0;
         fe_q <= 1'b0;
         unique case (state)
            START: begin
               clk_cnt <= mid_start ? '0 : clk_cnt + 1'b1;
            end
            DATA: begin
               clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
               if (bit_end) begin
                  shift_reg[bit_idx] <= rx_s;
                  bit_idx            <= bit_idx + 1'b1;
               end
            end
            STOP: begin
               clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
               // byte is only published when the stop bit is good
               if (bit_end && rx_s) begin
                  byte_q <= shift_reg;
                  dv_q   <= 1'b1;
               end
               fe_q <= bit_end && !rx_s;
            end
            default: begin
               clk_cnt <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

   always_comb begin
      busy = (state != IDLE);
   end

   assign rx.o_Rx_DV     = dv_q;
   assign rx.o_Frame_Err = fe_q;
   assign rx.o_Rx_Byte   = byte_q;
   assign rx.o_Rx_Busy   = busy;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed and randomized 8N1 frames against a byte-queue reference.
// Bit timing is 8 clocks per bit.
module tb_uart_rx_deframer;
   import uart_pkg::*;

   localparam int CPB = 8;
   localparam int NOM = 2 + (CPB - 1) / 2 + 9 * CPB + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_deframer_if rx ();

   uart_rx_deframer #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int fall_cyc = 0;
   int dv_cyc = 0;
   int dv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int exp_fe = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx.o_Rx_DV) begin
         got_q.push_back(rx.o_Rx_Byte);
         dv_cnt++;
         dv_cyc = cyc;
      end
      if (rx.o_Frame_Err) fe_cnt++;
      if (rx.o_Rx_DV && rx.o_Frame_Err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // caller sits on a posedge; returns on the posedge ending the last cycle
   task automatic drive(input logic [7:0] b, input logic stop,
                        input int ncyc);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int c = 0; c < ncyc; c++) begin
         #1 rx.i_Rx_Serial = f[c / CPB];
         if (c == 0) fall_cyc = cyc;
         @(posedge clk);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      drive(b, stop, 10 * CPB);
      if (stop) exp_q.push_back(b);
      else exp_fe++;
   endtask

   task automatic idle(input int n);
      #1 rx.i_Rx_Serial = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic drain(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check(tag, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int k;
      int dv0;
      logic busy_first;
      logic [7:0] b;
      logic s;

      rx.i_Rx_Serial = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dv", rx.o_Rx_DV, 0);
      check("rst_fe", rx.o_Frame_Err, 0);
      check("rst_busy", rx.o_Rx_Busy, 0);
      check("rst_byte", rx.o_Rx_Byte, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      idle(4);

      send(8'hA5, 1'b1);
      lat = dv_cyc - fall_cyc;
      check("latency_in_tol", (lat >= NOM - 1 && lat <= NOM + 1), 1);
      idle(4);
      check("good_busy_low", rx.o_Rx_Busy, 0);
      check("good_byte", rx.o_Rx_Byte, 8'hA5);
      check("good_dv_cnt", dv_cnt, 1);
      check("good_fe_cnt", fe_cnt, 0);
      drain("good");

      #1 rx.i_Rx_Serial = 1'b0;
      repeat (2) @(posedge clk);
      #1 rx.i_Rx_Serial = 1'b1;
      busy_first = 1'b0;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) busy_first = rx.o_Rx_Busy;
         k = i;
         if (!rx.o_Rx_Busy) break;
      end
      check("fstart_seen", busy_first, 1);
      check("fstart_idle_5", (k <= 5 && !rx.o_Rx_Busy), 1);
      check("fstart_dv", dv_cnt, 1);
      check("fstart_fe", fe_cnt, 0);
      @(posedge clk);

      send(8'hA5, 1'b1);
      send(8'h3C, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      check("ferr_hold_busy", rx.o_Rx_Busy, 1);
      check("ferr_fe_cnt", fe_cnt, 1);
      check("ferr_dv_cnt", dv_cnt, 2);
      @(posedge clk);
      idle(6);
      check("ferr_release_idle", rx.o_Rx_Busy, 0);
      check("ferr_byte_kept", rx.o_Rx_Byte, 8'hA5);
      check("ferr_dv_after", dv_cnt, 2);
      drain("ferr");

      dv0 = dv_cnt;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      send(8'h81, 1'b1);
      idle(4);
      check("b2b_dv_cnt", dv_cnt - dv0, 3);
      drain("b2b");

      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom);
         s = ($urandom_range(3) != 0);
         send(b, s);
         if (!s) idle(2 * CPB);
         else idle($urandom_range(3));
      end
      idle(4);
      drain("rand");
      check("rand_fe_total", fe_cnt, exp_fe);

      dv0 = dv_cnt;
      drive(8'h55, 1'b1, 4 * CPB + CPB / 2);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_dv", rx.o_Rx_DV, 0);
      check("mid_rst_fe", rx.o_Frame_Err, 0);
      check("mid_rst_busy", rx.o_Rx_Busy, 0);
      check("mid_rst_byte", rx.o_Rx_Byte, 8'h00);
      rx.i_Rx_Serial = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      idle(2 * CPB);
      check("mid_rst_no_pulse", dv_cnt, dv0);
      send(8'h96, 1'b1);
      idle(4);
      check("post_rst_byte", rx.o_Rx_Byte, 8'h96);
      drain("post_rst");
      check("fe_total", fe_cnt, exp_fe);
      check("dv_fe_exclusive", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- UART receive stage; sits directly downstream of the serial line driven by the transmitter.
- Recovers 8N1 frames from an asynchronous serial input by mid-bit sampling.
- Presents each good byte with a one-cycle valid pulse (o_Rx_DV / o_Rx_Byte), consumed by the Tx→Rx scoreboard/checker.
- Flags framing errors and suppresses false start bits.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per serial bit (10 MHz / 115200). Elaboration-time assertion requires ≥ 4.
- DATA_BITS, 8, payload bits per frame, LSB first. Fixed at 8 for this revision.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_Rx_Serial  input  1  asynchronous serial line; idle high
- o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte holds a newly received good byte
- o_Rx_Byte  output  8  last good byte; held until the next good frame
- o_Frame_Err  output  1  one-cycle pulse; stop bit sampled low
- o_Rx_Busy  output  1  high while in any state other than IDLE

Behaviour:
- Reset values:
  - o_Rx_DV = 0, o_Frame_Err = 0, o_Rx_Busy = 0, o_Rx_Byte = 8'h00.
  - Synchronizer flops reset to 1 (line-idle value), so no spurious start is detected.
  - State = IDLE; bit counter and bit index = 0.
- Input path:
  - 2-flop synchronizer on i_Rx_Serial; rx_s is its output (2 clk latency).
  - All decisions use rx_s only.
- Clock counter:
  - clk_cnt counts 0..CLKS_PER_BIT-1.
  - Width is $clog2(CLKS_PER_BIT).
- States:
  - IDLE:
    - clk_cnt = 0, bit_idx = 0.
    - When rx_s = 0, go to START.
  - START:
    - Count up to (CLKS_PER_BIT-1)/2, which is mid start bit.
    - At that count, if rx_s = 0, clear clk_cnt and go to DATA.
    - Otherwise (glitch) return to IDLE with no output activity.
  - DATA:
    - Count to CLKS_PER_BIT-1, then sample rx_s into shift_reg[bit_idx] and clear clk_cnt.
    - After bit_idx = 7 is sampled, go to STOP; otherwise increment bit_idx.
  - STOP:
    - Count to CLKS_PER_BIT-1, then sample rx_s.
    - If 1: next cycle o_Rx_Byte ← shift_reg and o_Rx_DV = 1 for exactly one cycle; go to CLEANUP.
    - If 0: next cycle o_Frame_Err = 1 for exactly one cycle; o_Rx_Byte unchanged; go to BREAK_WAIT.
  - CLEANUP: one cycle, then go to IDLE.
  - BREAK_WAIT: hold until rx_s = 1, then go to IDLE. A line held low never re-triggers START.
- o_Rx_DV and o_Frame_Err are mutually exclusive and never asserted in the same cycle.
- Latency: falling edge on i_Rx_Serial to o_Rx_DV ≈ 2 + (CLKS_PER_BIT-1)/2 + 9·CLKS_PER_BIT + 1 cycles.
  - Tolerance of ±1 cycle is allowed in the bench; the exact value must be documented in the RTL header.
- Back-to-back frames: a start bit beginning immediately after the stop bit is detected, because the CLEANUP→IDLE path costs ≤ 2 cycles, well inside half a bit.
- Reset mid-frame:
  - rst_n low forces the reset values immediately.
  - The partial frame is discarded and no pulse is emitted.
  - After release, the block waits in IDLE; if the line is mid-frame low, it may resynchronize on the next falling edge.

Decomposition:
- Shared package uart_pkg contains:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, CLEANUP, BREAK_WAIT}
  - localparam DATA_BITS = 8
  - default CLKS_PER_BIT constant, shared with the transmitter.
- One sub-module: uart_sync_2ff.
  - Parameterised reset value; used for i_Rx_Serial and reusable elsewhere.

Test Plan:
- Setup: CLKS_PER_BIT = 8; the bench drives ideal 8N1 frames at 8 clk/bit.
- Good frame: send 0xA5 → exactly one o_Rx_DV pulse, o_Rx_Byte = 8'hA5, o_Frame_Err never high, o_Rx_Busy returns low.
- False start: drive the line low for 2 cycles, then high → no o_Rx_DV, no o_Frame_Err, state back to IDLE within 5 cycles.
- Framing error:
  - Send 0xA5 (good), then 0x3C with stop bit = 0, line held low 20 more cycles, then high.
  - Required: one o_Frame_Err pulse, no second o_Rx_DV, o_Rx_Byte stays 8'hA5, no new start detected until the line rises.
- Back-to-back frames: send 0x00, 0xFF, 0x81 with zero idle gap → three o_Rx_DV pulses carrying 00, FF, 81 in order.
- Reset mid-frame:
  - Assert rst_n low during data bit 3 of 0x55.
  - Required: outputs at reset values immediately, no pulse.
  - A subsequent clean 0x96 frame gives o_Rx_Byte = 8'h96.
